// File: rtl/i2c_temp_responder.sv
// I2C read-only target emulating the LM75 temperature register.
// Returns a 16-bit word, MSB byte first, on a read to DEVICE_ADDR.
module i2c_temp_responder #(
    parameter logic [6:0] DEVICE_ADDR = 7'h48
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl,
    inout  wire         sda,
    input  logic [15:0] temp_data,
    output logic        busy,
    output logic        read_done
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        TX,
        MACK,
        WAIT_STOP
    } state_t;

    state_t      state;
    logic [2:0]  scl_q;
    logic [2:0]  sda_q;
    logic        sda_low;
    logic [7:0]  shreg;
    logic [15:0] tx_word;
    logic [3:0]  bit_cnt;
    logic        byte_idx;
    logic        mack_ok;

    logic scl_s, scl_h, sda_s, sda_h;
    logic rise, fall, start_ev, stop_ev;
    logic [7:0] next_byte;

    // Open-drain pin; the release is combinational on sda_low so reset frees the bus at once
    assign sda = sda_low ? 1'b0 : 1'bz;

    // Stages [1:0] synchronise, [2] holds the previous sample for edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign scl_s    = scl_q[1];
    assign scl_h    = scl_q[2];
    assign sda_s    = sda_q[1];
    assign sda_h    = sda_q[2];
    assign rise     = scl_s & ~scl_h;
    assign fall     = ~scl_s & scl_h;
    assign start_ev = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_ev  = scl_s & scl_h & ~sda_h & sda_s;

    assign next_byte = byte_idx ? tx_word[15:8] : tx_word[7:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sda_low   <= 1'b0;
            busy      <= 1'b0;
            read_done <= 1'b0;
            shreg     <= 8'h00;
            tx_word   <= 16'h0000;
            bit_cnt   <= 4'd0;
            byte_idx  <= 1'b0;
            mack_ok   <= 1'b0;
        end else begin
            read_done <= 1'b0;
            if (stop_ev) begin
                state   <= IDLE;
                sda_low <= 1'b0;
                busy    <= 1'b0;
            end else if (start_ev) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_low <= 1'b0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: sda_low <= 1'b0;
                    ADDR: begin
                        if (rise && !bit_cnt[3]) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (shreg == {DEVICE_ADDR, 1'b1}) begin
                                sda_low <= 1'b1;
                                tx_word <= temp_data;
                                busy    <= 1'b1;
                                state   <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (fall) begin
                            shreg    <= tx_word[15:8];
                            sda_low  <= ~tx_word[15];
                            bit_cnt  <= 4'd0;
                            byte_idx <= 1'b0;
                            state    <= TX;
                        end
                    end
                    TX: begin
                        if (fall) begin
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                sda_low <= 1'b0;
                                state   <= MACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_low <= ~shreg[6];
                            end
                        end
                    end
                    MACK: begin
                        if (rise) begin
                            mack_ok <= ~sda_s;
                        end else if (fall) begin
                            if (mack_ok) begin
                                byte_idx <= ~byte_idx;
                                shreg    <= next_byte;
                                sda_low  <= ~next_byte[7];
                                state    <= TX;
                            end else begin
                                read_done <= 1'b1;
                                busy      <= 1'b0;
                                state     <= WAIT_STOP;
                            end
                        end
                    end
                    WAIT_STOP: sda_low <= 1'b0;
                    default: begin
                        sda_low <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Bench for i2c_temp_responder: bit-banged I2C master, vector table
// plus directed sequences, with a byte scoreboard.
`timescale 1ns/1ps
module tb_i2c_temp_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    logic [15:0] temp_data = 16'h0000;
    logic        busy;
    logic        read_done;
    tri1         sda;

    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_temp_responder #(.DEVICE_ADDR(7'h48)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .scl(scl),
        .sda(sda),
        .temp_data(temp_data),
        .busy(busy),
        .read_done(read_done)
    );

    always #10 clk = ~clk;

    int n_tot = 0;
    int n_pass = 0;
    int rd_pulses = 0;
    int busy_cyc = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        if (reset_n && read_done) rd_pulses <= rd_pulses + 1;
        if (reset_n && busy) busy_cyc <= busy_cyc + 1;
    end

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] temp;
        int          nbytes;
        logic        ack;
    } vec_t;

    vec_t vecs[5];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic chk_byte(input string name, input logic [7:0] got);
        if (exp_q.size() == 0) begin
            n_tot++;
            $display("FAIL %s: got %0h expected (scoreboard empty)", name, got);
        end else begin
            chk(name, {24'h0, got}, {24'h0, exp_q.pop_front()});
        end
    endtask

    // Works from idle (scl high) and as a repeated START (scl low)
    task automatic bus_start();
        m_low = 1'b0;
        tick(50);
        scl = 1'b1;
        tick(50);
        m_low = 1'b1;
        tick(50);
        scl = 1'b0;
        tick(50);
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        tick(50);
        scl = 1'b1;
        tick(50);
        m_low = 1'b0;
        tick(100);
    endtask

    task automatic clk_bit(input logic drv, output logic smp);
        m_low = ~drv;
        tick(50);
        scl = 1'b1;
        tick(50);
        smp = sda;
        tick(50);
        scl = 1'b0;
        tick(50);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(~m_ack, s);
    endtask

    task automatic run_read(input logic [7:0] addr, input logic [15:0] temp,
                            input int nbytes, input logic exp_ack);
        logic acked;
        logic [7:0] b;
        int rd0, bz0;
        rd0 = rd_pulses;
        bz0 = busy_cyc;
        temp_data = temp;
        bus_start();
        send_byte(addr, acked);
        chk("addr_ack", acked, exp_ack);
        chk("busy_after_ack", busy, exp_ack);
        if (exp_ack) begin
            for (int k = 0; k < nbytes; k++) begin
                exp_q.push_back(k[0] ? temp[7:0] : temp[15:8]);
                read_byte(k < nbytes - 1, b);
                chk_byte("rd_byte", b);
            end
            chk("read_done_pulses", rd_pulses - rd0, 1);
            chk("busy_after_nack", busy, 0);
        end else begin
            exp_q.push_back(8'hFF);
            read_byte(1'b0, b);
            chk_byte("nomatch_sda_released", b);
            chk("nomatch_busy_never", busy_cyc - bz0, 0);
            chk("nomatch_no_read_done", rd_pulses - rd0, 0);
        end
        bus_stop();
        chk("sda_released_after_stop", sda, 1);
        chk("busy_after_stop", busy, 0);
    endtask

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        logic acked;
        logic s;
        logic [7:0] b;
        int rd0, bz0;

        vecs[0] = '{addr: 8'h91, temp: 16'h1A80, nbytes: 2, ack: 1'b1};
        vecs[1] = '{addr: 8'h93, temp: 16'h1A80, nbytes: 0, ack: 1'b0};
        vecs[2] = '{addr: 8'h90, temp: 16'h1A80, nbytes: 0, ack: 1'b0};
        vecs[3] = '{addr: 8'h91, temp: 16'hC3A5, nbytes: 3, ack: 1'b1};
        vecs[4] = '{addr: 8'h91, temp: 16'h0F00, nbytes: 2, ack: 1'b1};

        tick(5);
        chk("reset_sda", sda, 1);
        chk("reset_busy", busy, 0);
        chk("reset_read_done", read_done, 0);
        reset_n = 1'b1;
        tick(10);

        for (int v = 0; v < 5; v++)
            run_read(vecs[v].addr, vecs[v].temp, vecs[v].nbytes, vecs[v].ack);

        // temp_data changes after the latch; the transfer keeps the old word
        temp_data = 16'h1A80;
        bus_start();
        send_byte(8'h91, acked);
        chk("chg_ack", acked, 1);
        temp_data = 16'hFFFF;
        exp_q.push_back(8'h1A);
        read_byte(1'b1, b);
        chk_byte("chg_byte1", b);
        exp_q.push_back(8'h80);
        read_byte(1'b0, b);
        chk_byte("chg_byte2", b);
        bus_stop();
        run_read(8'h91, 16'hFFFF, 2, 1'b1);

        // Asynchronous reset while the target drives sda low
        temp_data = 16'h1A80;
        bus_start();
        send_byte(8'h91, acked);
        chk("rst_ack", acked, 1);
        chk("rst_pre_sda_low", sda, 0);
        @(posedge clk);
        #5;
        reset_n = 1'b0;
        #1;
        chk("rst_async_sda", sda, 1);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_read_done", read_done, 0);
        tick(2);
        reset_n = 1'b1;
        rd0 = rd_pulses;
        bz0 = busy_cyc;
        exp_q.push_back(8'hFF);
        read_byte(1'b1, b);
        chk_byte("rst_ignored_bits", b);
        chk("rst_ignored_busy", busy_cyc - bz0, 0);
        bus_stop();
        chk("rst_no_read_done", rd_pulses - rd0, 0);

        // Repeated START after byte 1 re-latches and restarts at MSB byte
        temp_data = 16'h1A80;
        bus_start();
        send_byte(8'h91, acked);
        exp_q.push_back(8'h1A);
        read_byte(1'b1, b);
        chk_byte("rs_byte1", b);
        chk("rs_busy_before", busy, 1);
        temp_data = 16'h5A3C;
        bus_start();
        chk("rs_busy_after_start", busy, 0);
        send_byte(8'h91, acked);
        chk("rs_ack", acked, 1);
        exp_q.push_back(8'h5A);
        read_byte(1'b1, b);
        chk_byte("rs_new_msb", b);
        exp_q.push_back(8'h3C);
        read_byte(1'b0, b);
        chk_byte("rs_new_lsb", b);
        bus_stop();

        // STOP in the middle of a byte returns to IDLE
        temp_data = 16'hFFFF;
        bus_start();
        send_byte(8'h91, acked);
        chk("stopmid_ack", acked, 1);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
        bus_stop();
        chk("stopmid_sda", sda, 1);
        chk("stopmid_busy", busy, 0);
        scl = 1'b0;
        tick(50);
        send_byte(8'h91, acked);
        chk("stopmid_idle_no_ack", acked, 0);
        bus_stop();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
